// File: rtl/sinc_pipe.sv
// sinc_pipe: registered signed incrementer (d = a + 1) with valid/ready
// handshakes and a 2-entry output buffer (head register + tail register).
//
// Parameters:
//   DATAWIDTH  operand/result width, two's complement, >= 2
// Ports:
//   Clk        rising-edge clock
//   Rst        asynchronous active-low reset
//   a          signed operand
//   in_valid   a is valid this cycle
//   in_ready   stage can accept an operand (registered)
//   d          signed result at the buffer head (registered)
//   ovf        overflow flag of the head entry (a was max positive)
//   out_valid  d/ovf are valid
//   out_ready  consumer accepts d this cycle
//
// Build option:
//   SINC_PIPE_SAT_EN  defined: max positive input saturates to max positive;
//                     undefined (default): two's-complement wrap.
module sinc_pipe #(
    parameter int DATAWIDTH = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [DATAWIDTH-1:0] MAXP =
        {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam logic [DATAWIDTH-1:0] ONE =
        {{(DATAWIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           count;
    logic [1:0]           next_count;
    logic [DATAWIDTH-1:0] tail_d;
    logic                 tail_ovf;
    logic [DATAWIDTH-1:0] new_d;
    logic                 new_ovf;
    logic                 push;
    logic                 pop;
    logic                 load_head;
    logic                 shift;
    logic                 load_tail;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);

    always_comb begin
        new_ovf = (a == MAXP);
`ifdef SINC_PIPE_SAT_EN
        new_d = new_ovf ? MAXP : a + ONE;
`else
        new_d = a + ONE;
`endif
    end

    always_comb begin
        next_count = count;
        unique case ({push, pop})
            2'b10:   next_count = count + 2'd1;
            2'b01:   next_count = count - 2'd1;
            default: next_count = count;
        endcase
    end

    // Head takes the new entry when it is (or is about to be) empty;
    // it takes the tail when the head pops with two entries buffered.
    // The tail takes the new entry whenever the head stays occupied.
    always_comb begin
        load_head = push && ((count == 2'd0) ||
                             ((count == 2'd1) && pop));
        shift     = pop && (count == 2'd2);
        load_tail = push && (((count == 2'd1) && !pop) ||
                             ((count == 2'd2) && pop));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count    <= 2'd0;
            in_ready <= 1'b0;
            d        <= '0;
            ovf      <= 1'b0;
            tail_d   <= '0;
            tail_ovf <= 1'b0;
        end else begin
            count    <= next_count;
            in_ready <= (next_count < 2'd2);
            if (load_head) begin
                d   <= new_d;
                ovf <= new_ovf;
            end else if (shift) begin
                d   <= tail_d;
                ovf <= tail_ovf;
            end
            if (load_tail) begin
                tail_d   <= new_d;
                tail_ovf <= new_ovf;
            end
        end
    end

endmodule

// File: tb/tb_sinc_pipe.sv
// tb_sinc_pipe: directed, table-driven bench for sinc_pipe at DATAWIDTH = 4.
// Vectors set inputs, clock once, then compare the registered outputs.
module tb_sinc_pipe;

    logic       Clk;
    logic       Rst;
    logic [3:0] a;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] d;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    int checks;
    int errors;

    typedef struct {
        logic       v;
        logic [3:0] a;
        logic       ordy;
        logic       e_ov;
        logic       e_ir;
        logic       e_chkd;
        logic [3:0] e_d;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    sinc_pipe #(.DATAWIDTH(4)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .a         (a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic v, input logic [3:0] av, input logic ordy,
        input logic e_ov, input logic e_ir, input logic e_chkd,
        input logic [3:0] e_d, input logic e_ovf);
        vec_t r;
        r.v = v; r.a = av; r.ordy = ordy;
        r.e_ov = e_ov; r.e_ir = e_ir; r.e_chkd = e_chkd;
        r.e_d = e_d; r.e_ovf = e_ovf;
        return r;
    endfunction

    task automatic chk_out(input string tag, input logic e_ov,
                           input logic e_ir, input logic [3:0] e_d,
                           input logic e_ovf, input logic chkd);
        chk({tag, ".out_valid"}, int'(out_valid), int'(e_ov));
        chk({tag, ".in_ready"}, int'(in_ready), int'(e_ir));
        if (chkd) begin
            chk({tag, ".d"}, int'(d), int'(e_d));
            chk({tag, ".ovf"}, int'(ovf), int'(e_ovf));
        end
    endtask

    initial begin
        logic [3:0] max_res;
        checks    = 0;
        errors    = 0;
        Rst       = 1'b0;
        a         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef SINC_PIPE_SAT_EN
        max_res = 4'd7;
`else
        max_res = 4'h8;
`endif

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("rst%0d", i), 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        end
        Rst = 1'b1;
        #1;
        chk("rel.in_ready_before_edge", int'(in_ready), 0);
        tick();
        chk_out("rel", 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);

        // streaming
        tbl.push_back(mk(1, 4'(-3), 1, 1, 1, 1, 4'(-2), 0));
        tbl.push_back(mk(1, 4'(-1), 1, 1, 1, 1, 4'(0), 0));
        tbl.push_back(mk(1, 4'(0), 1, 1, 1, 1, 4'(1), 0));
        tbl.push_back(mk(1, 4'(5), 1, 1, 1, 1, 4'(6), 0));
        // overflow and min negative
        tbl.push_back(mk(1, 4'(7), 1, 1, 1, 1, max_res, 1));
        tbl.push_back(mk(1, 4'(-8), 1, 1, 1, 1, 4'(-7), 0));
        tbl.push_back(mk(0, 4'(0), 1, 0, 1, 0, 4'(0), 0));
        // backpressure: 1 and 2 accepted, 3 held off
        tbl.push_back(mk(1, 4'(1), 0, 1, 1, 1, 4'(2), 0));
        tbl.push_back(mk(1, 4'(2), 0, 1, 0, 1, 4'(2), 0));
        tbl.push_back(mk(1, 4'(3), 0, 1, 0, 1, 4'(2), 0));
        tbl.push_back(mk(1, 4'(3), 1, 1, 1, 1, 4'(3), 0));
        tbl.push_back(mk(1, 4'(3), 1, 1, 1, 1, 4'(4), 0));
        tbl.push_back(mk(0, 4'(0), 1, 0, 1, 0, 4'(0), 0));
        // push and pop together at count = 1
        tbl.push_back(mk(1, 4'(-6), 0, 1, 1, 1, 4'(-5), 0));
        tbl.push_back(mk(1, 4'(2), 1, 1, 1, 1, 4'(3), 0));
        tbl.push_back(mk(1, 4'(-2), 1, 1, 1, 1, 4'(-1), 0));
        tbl.push_back(mk(0, 4'(0), 1, 0, 1, 0, 4'(0), 0));

        foreach (tbl[i]) begin
            in_valid  = tbl[i].v;
            a         = tbl[i].a;
            out_ready = tbl[i].ordy;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir,
                    tbl[i].e_d, tbl[i].e_ovf, tbl[i].e_chkd);
        end

        // mid-transfer reset with two entries buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 4'd4;
        tick();
        a = 4'd5;
        tick();
        chk_out("fill", 1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
        in_valid = 1'b0;
        #3;
        Rst = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        Rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_out("post_rst", 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stale%0d.out_valid", i), int'(out_valid), 0);
        end
        in_valid = 1'b1;
        a        = 4'(-1);
        tick();
        chk_out("post_push", 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("post_pop.out_valid", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sinc_pipe.md
# sinc_pipe

Registered signed incrementer stage with a valid/ready handshake on both sides and a 2-entry output buffer. It computes `d = a + 1` on each accepted operand. It is the increment counterpart to the combinational signed decrementer. It drops into generated datapaths wherever an incrementing step must be pipelined and tolerate downstream stalls.

## Interface

Parameters:
- `DATAWIDTH`, default 2. Operand and result width in bits, two's complement; legal range ≥ 2.

Ports:
- `Clk`, input, 1 bit. Rising-edge clock.
- `Rst`, input, 1 bit. Reset, asynchronous assert, active-low.
- `a`, input, `DATAWIDTH` bits. Signed operand.
- `in_valid`, input, 1 bit. `a` is valid this cycle.
- `in_ready`, output, 1 bit. Stage can accept an operand this cycle.
- `d`, output, `DATAWIDTH` bits. Signed result at the buffer head.
- `ovf`, output, 1 bit. Overflow flag for the head entry.
- `out_valid`, output, 1 bit. `d`/`ovf` are valid.
- `out_ready`, input, 1 bit. Consumer accepts `d` this cycle.

One clock; reset is asynchronous and active-low.

## Operation

- Accept (push) occurs when `in_valid && in_ready` at a rising edge. Pop occurs when `out_valid && out_ready` at a rising edge.
- Pushed entry: result = `a + 1` truncated to `DATAWIDTH` (wrap). `ovf` = 1 iff `a` equals the max positive value (`0` followed by all ones).
- Buffer:
  - 2-entry FIFO: `count` ∈ {0, 1, 2}, with head/tail pointers or a shift pair.
  - `d`, `ovf` and `out_valid` come from the head entry (registered, no combinational path from `a`).
- `in_ready`:
  - Registered; equals `(next_count < 2)`.
  - No combinational path from `out_ready` to `in_ready`.
- Simultaneous push and pop:
  - `count` unchanged.
  - Head advances; the new entry goes to the tail.
  - Order is preserved.
- Push while `in_ready` = 0 is impossible by definition; `in_valid` is ignored.
- Pop with `count` = 0 is impossible (`out_valid` = 0).
- Empty state: `d`/`ovf` hold the last popped values; they are don't-care for checking, and the implementation holds them.
- Reset (any time, including mid-transfer):
  - `count` = 0, all entries cleared.
  - `d` = 0, `ovf` = 0, `out_valid` = 0, `in_ready` = 0.
  - Buffered data is discarded.
- After `Rst` deasserts, `in_ready` rises at the first rising edge.

## Timing

- Latency: operand pushed at edge N appears with `out_valid` = 1 after edge N (visible in cycle N+1) when the buffer was empty.
- Throughput: 1 result/cycle while `out_ready` stays high.
- Stall behaviour:
  - With `out_ready` = 0, the stage absorbs 2 operands.
  - `in_ready` drops after the edge that makes `count` = 2.
  - `in_ready` returns high after the edge that pops one entry.
- `d`, `ovf` and `out_valid` are stable while `out_valid && !out_ready`.

## Configuration

- Macro `SINC_PIPE_SAT_EN`:
  - **Defined:** result saturates. Max positive input yields max positive output (no wrap to min negative), and `ovf` = 1.
  - **Undefined (default):** two's-complement wrap. Max positive input yields min negative output, and `ovf` = 1.
- All other inputs behave identically in both builds.

## Test plan

All scenarios use `DATAWIDTH` = 4.

1. **Reset release:** hold `Rst` = 0 for 3 cycles, then release. Required: `d` = 0, `out_valid` = 0, `ovf` = 0 throughout reset; `in_ready` = 0 during reset and 1 after the first edge.
2. **Streaming:** push `a` = -3, -1, 0, 5 on consecutive cycles with `out_ready` = 1. Required: `d` = -2, 0, 1, 6 on consecutive cycles, each one cycle after its push, with `ovf` = 0.
3. **Overflow:** push `a` = 7.
   - Wrap build: `d` = -8, `ovf` = 1.
   - `SINC_PIPE_SAT_EN` build: `d` = 7, `ovf` = 1.
   - Also push `a` = -8: required `d` = -7, `ovf` = 0.
4. **Backpressure:** hold `out_ready` = 0 and offer `a` = 1, 2, 3.
   - Required: 1 and 2 accepted, `in_ready` = 0 on the third.
   - Raise `out_ready`: outputs 2, 3, then 4 in order, with no loss or duplication.
5. **Simultaneous push/pop at `count` = 1:** `count` stays 1, order is preserved, `in_ready` stays 1.
6. **Mid-transfer reset:** assert `Rst` with 2 entries buffered. Required: `out_valid` = 0 immediately (async), and no stale entries appear after release.
